extend_unit: RTL and testbench
==============================

Name: extend_unit

Overview:
Parametrised, registered data-extension stage for the semiMIPS datapath. It performs immediate extension (sign, zero, LUI) and load-data extension (LB/LBU/LH/LHU/LW lane select) in one block. It sits between the memory/decode stage and writeback/ALU-operand muxing, with a one-deep valid/ready pipeline register so it can absorb downstream stalls.

Parameters:
DWIDTH, 32, output/load-word width; power of two, >= 16, multiple of 16
IMMWIDTH, 16, immediate field width; 1 <= IMMWIDTH <= DWIDTH
OFFW, $clog2(DWIDTH/8), byte-offset width (derived localparam, not overridable)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  input beat valid
in_ready  output  1  block can accept a beat this cycle
in_mode  input  3  operation select (encoding below)
in_imm  input  IMMWIDTH  immediate operand
in_word  input  DWIDTH  raw load word from memory
in_offset  input  OFFW  byte address low bits of the load
out_valid  output  1  result valid
out_ready  input  1  downstream accepts result
out_data  output  DWIDTH  extended result
out_misalign  output  1  misaligned-access flag (see Optional Feature)

Behaviour:
- Reset (rst_n low, asynchronous): out_valid=0, out_data=0, out_misalign=0. in_ready reads 1 during and after reset.
- Handshake: a beat transfers on in_valid&&in_ready, and is delivered on out_valid&&out_ready.
- in_ready = !out_valid || out_ready. This is combinational, with no in_ready→in_valid dependency.
- Latency: exactly 1 cycle. A beat accepted at edge N appears with out_valid=1 after edge N.
- Register update:
  - If the input is accepted, out_data/out_misalign load the new result and out_valid=1.
  - Else if out_ready, out_valid=0 and data holds.
  - Else all outputs hold. out_data must stay stable while out_valid&&!out_ready.
- Simultaneous drain and accept (out_valid=1, out_ready=1, in_valid=1): the old beat leaves, the new beat loads the same edge, and out_valid stays 1. Full throughput is 1 beat/cycle.
- Mode encoding (little-endian lanes; lane b = in_word[8b+7:8b]):
  - 0 SEXT: {(DWIDTH-IMMWIDTH) copies of in_imm[IMMWIDTH-1], in_imm}
  - 1 ZEXT: zero-fill, in_imm
  - 2 LUI: in_imm placed in the top IMMWIDTH bits, lower bits 0
  - 3 LB: byte lane in_offset, sign-extended
  - 4 LBU: byte lane in_offset, zero-extended
  - 5 LH: halfword lane in_offset[OFFW-1:1], sign-extended; in_offset[0] ignored for data
  - 6 LHU: as LH, zero-extended
  - 7 LW: in_word unchanged; in_offset ignored for data
- Immediate modes (0–2) ignore in_word and in_offset.
- When IMMWIDTH == DWIDTH, SEXT, ZEXT and LUI all return in_imm.
- Inputs are sampled only on the accepting edge. Changes while not accepted have no effect.
- Reset asserted mid-transfer discards the held beat. The first post-reset cycle has out_valid=0.

Optional Feature:
Macro EXTEND_ALIGN_CHECK_EN.
- Defined: out_misalign is set with the beat under either condition:
  - LH/LHU with in_offset[0]=1
  - LW with in_offset != 0
  out_data is computed identically; the flag is informational, for the exception logic.
- Undefined: out_misalign is constant 0 and no check logic is synthesised. The port remains present.

Test Plan:
- Reset, then SEXT in_imm=16'h8001 with out_ready=1 → next cycle out_valid=1, out_data=32'hFFFF8001. ZEXT of the same value → 32'h00008001. LUI of 16'h1234 → 32'h12340000.
- LB/LBU with in_word=32'h80FF7F01, offsets 0..3:
  - LB → 0x00000001, 0x0000007F, 0xFFFFFFFF, 0xFFFFFF80
  - LBU offset 2 → 0x000000FF
- LH offset 2 on 32'h8000_1234 → 0xFFFF8000; LHU offset 0 → 0x00001234. LW offset 0 → 0x80001234.
- Back-pressure: hold out_ready=0 with 3 beats presented. The first beat's out_data stays stable and in_ready=0 until release. Then release and stream 3 beats back-to-back at 1 beat/cycle, with no loss or duplication.
- Assert rst_n low asynchronously mid-cycle while out_valid=1 → out_valid drops immediately, out_data=0. After release, the first accepted beat is output normally.
- With EXTEND_ALIGN_CHECK_EN defined:
  - LH offset 1 and LW offset 2 → out_misalign=1
  - LH offset 2 → out_misalign=0
  Without the macro, all of the above give out_misalign=0 with out_data unchanged.

Source files
------------

// File: rtl/extend_unit.sv
// extend_unit: registered immediate/load-data extension stage with a one-deep valid/ready slot.
// Optional misalignment flag enabled by defining EXTEND_ALIGN_CHECK_EN.
module extend_unit #(
  parameter int DWIDTH   = 32,
  parameter int IMMWIDTH = 16,
  localparam int OFFW    = $clog2(DWIDTH/8)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [2:0]          in_mode,
  input  logic [IMMWIDTH-1:0] in_imm,
  input  logic [DWIDTH-1:0]   in_word,
  input  logic [OFFW-1:0]     in_offset,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DWIDTH-1:0]   out_data,
  output logic                out_misalign
);
  localparam logic [2:0] SEXT = 3'd0, ZEXT = 3'd1, LUI = 3'd2, LB = 3'd3,
                         LBU = 3'd4, LH = 3'd5, LHU = 3'd6, LW = 3'd7;
  logic [DWIDTH-1:0] sext, zext, lui, res;
  logic [OFFW-1:0]   half_off;
  logic [7:0]        lane_b;
  logic [15:0]       lane_h;
  logic              mis;
  assign sext     = DWIDTH'($signed(in_imm));
  assign zext     = DWIDTH'(in_imm);
  assign lui      = zext << (DWIDTH - IMMWIDTH);
  // halfword lane = byte offset with bit 0 cleared, so the same byte shift serves both
  assign half_off = in_offset & ~OFFW'(1);
  assign lane_b   = 8'(in_word >> {in_offset, 3'b000});
  assign lane_h   = 16'(in_word >> {half_off, 3'b000});
  always_comb
    res = in_mode == SEXT ? sext :
          in_mode == ZEXT ? zext :
          in_mode == LUI  ? lui :
          in_mode == LB   ? DWIDTH'($signed(lane_b)) :
          in_mode == LBU  ? DWIDTH'(lane_b) :
          in_mode == LH   ? DWIDTH'($signed(lane_h)) :
          in_mode == LHU  ? DWIDTH'(lane_h) : in_word;
`ifdef EXTEND_ALIGN_CHECK_EN
  assign mis = ((in_mode == LH || in_mode == LHU) && in_offset[0]) ||
               (in_mode == LW && in_offset != '0);
`else
  assign mis = 1'b0;
`endif
  assign in_ready = !out_valid || out_ready;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      out_valid    <= 1'b0;
      out_data     <= '0;
      out_misalign <= 1'b0;
    end else if (in_valid && in_ready) begin
      out_valid    <= 1'b1;
      out_data     <= res;
      out_misalign <= mis;
    end else if (out_ready) begin
      out_valid    <= 1'b0;
    end
endmodule

// File: tb/tb_extend_unit.sv
// tb_extend_unit: vector table, handshake corner sequences and randomized scoreboard for extend_unit.
module tb_extend_unit;
  logic        clk = 0, rst_n = 0, in_valid = 0, out_ready = 1;
  logic        in_ready, out_valid, out_misalign;
  logic [2:0]  in_mode = 0;
  logic [15:0] in_imm = 0;
  logic [31:0] in_word = 0, out_data;
  logic [1:0]  in_offset = 0;
  int passed = 0, total = 0;
  bit align_en;

  extend_unit dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_mode(in_mode), .in_imm(in_imm), .in_word(in_word), .in_offset(in_offset),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_misalign(out_misalign)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [2:0]  mode;
    logic [15:0] imm;
    logic [31:0] word;
    logic [1:0]  off;
    logic [31:0] exp_data;
    logic        exp_mis;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // reference: spec rules in plain integer arithmetic; returns {misalign, data}
  function automatic logic [32:0] ref_m(input logic [2:0] m, input logic [15:0] imm,
                                        input logic [31:0] w, input logic [1:0] off);
    longint v;
    bit mis;
    mis = 0;
    case (m)
      0: begin v = imm; if (v >= 32768) v -= 65536; end
      1: v = imm;
      2: v = longint'(imm) * 65536;
      3, 4: begin v = (longint'(w) >> (8 * off)) % 256; if (m == 3 && v >= 128) v -= 256; end
      5, 6: begin
        v = (longint'(w) >> (16 * (off / 2))) % 65536;
        if (m == 5 && v >= 32768) v -= 65536;
        mis = off % 2 == 1;
      end
      default: begin v = w; mis = off != 0; end
    endcase
    return {mis & align_en, 32'(v)};
  endfunction

  task automatic drive(input logic [2:0] m, input logic [15:0] imm,
                       input logic [31:0] w, input logic [1:0] off);
    in_valid = 1; in_mode = m; in_imm = imm; in_word = w; in_offset = off;
  endtask

  vec_t vecs[$];
  logic [32:0] e, ea, eb, ec, ed;
  bit mv, mm, iv, orr;
  logic [31:0] md;

  initial begin
`ifdef EXTEND_ALIGN_CHECK_EN
    align_en = 1;
`else
    align_en = 0;
`endif
    vecs.push_back('{"sext_neg", 0, 16'h8001, 32'hDEADBEEF, 2'd3, 32'hFFFF8001, 0});
    vecs.push_back('{"sext_pos", 0, 16'h7FFF, 32'h12345678, 2'd1, 32'h00007FFF, 0});
    vecs.push_back('{"zext",     1, 16'h8001, 32'hFFFFFFFF, 2'd2, 32'h00008001, 0});
    vecs.push_back('{"lui",      2, 16'h1234, 32'hCAFEF00D, 2'd1, 32'h12340000, 0});
    vecs.push_back('{"lb0",      3, 16'h0,    32'h80FF7F01, 2'd0, 32'h00000001, 0});
    vecs.push_back('{"lb1",      3, 16'h0,    32'h80FF7F01, 2'd1, 32'h0000007F, 0});
    vecs.push_back('{"lb2",      3, 16'h0,    32'h80FF7F01, 2'd2, 32'hFFFFFFFF, 0});
    vecs.push_back('{"lb3",      3, 16'h0,    32'h80FF7F01, 2'd3, 32'hFFFFFF80, 0});
    vecs.push_back('{"lbu2",     4, 16'h0,    32'h80FF7F01, 2'd2, 32'h000000FF, 0});
    vecs.push_back('{"lbu3",     4, 16'h0,    32'h80FF7F01, 2'd3, 32'h00000080, 0});
    vecs.push_back('{"lh2",      5, 16'h0,    32'h80001234, 2'd2, 32'hFFFF8000, 0});
    vecs.push_back('{"lhu0",     6, 16'h0,    32'h80001234, 2'd0, 32'h00001234, 0});
    vecs.push_back('{"lhu2",     6, 16'h0,    32'h80001234, 2'd2, 32'h00008000, 0});
    vecs.push_back('{"lw0",      7, 16'h0,    32'h80001234, 2'd0, 32'h80001234, 0});
    vecs.push_back('{"lh1_mis",  5, 16'h0,    32'h80001234, 2'd1, 32'h00001234, 1});
    vecs.push_back('{"lhu3_mis", 6, 16'h0,    32'h80001234, 2'd3, 32'h00008000, 1});
    vecs.push_back('{"lw2_mis",  7, 16'h0,    32'h80001234, 2'd2, 32'h80001234, 1});
    // reset state
    #12;
    check("rst_valid", out_valid, 0);
    check("rst_data", out_data, 0);
    check("rst_mis", out_misalign, 0);
    check("rst_ready", in_ready, 1);
    @(negedge clk) rst_n = 1;
    @(posedge clk) #1;
    check("post_rst_valid", out_valid, 0);
    // table vectors, streamed one per cycle
    foreach (vecs[i]) begin
      drive(vecs[i].mode, vecs[i].imm, vecs[i].word, vecs[i].off);
      @(posedge clk) #1;
      check({vecs[i].name, "_valid"}, out_valid, 1);
      check(vecs[i].name, out_data, vecs[i].exp_data);
      check({vecs[i].name, "_mis"}, out_misalign, vecs[i].exp_mis & align_en);
    end
    in_valid = 0;
    @(posedge clk) #1;
    check("drain_valid", out_valid, 0);
    // back-pressure: first beat held, then three beats back-to-back
    ea = ref_m(3, 0, 32'h80FF7F01, 3); eb = ref_m(5, 0, 32'h80001234, 2);
    ec = ref_m(0, 16'hA5A5, 0, 0);     ed = ref_m(7, 0, 32'h13572468, 0);
    out_ready = 0;
    drive(3, 0, 32'h80FF7F01, 3);
    @(posedge clk) #1;
    check("bp_a_valid", out_valid, 1);
    check("bp_a_data", out_data, ea[31:0]);
    drive(5, 0, 32'h80001234, 2);
    repeat (3) begin
      #1 check("bp_ready_low", in_ready, 0);
      @(posedge clk) #1;
      check("bp_hold_data", out_data, ea[31:0]);
      check("bp_hold_valid", out_valid, 1);
    end
    out_ready = 1;
    #1 check("bp_ready_high", in_ready, 1);
    @(posedge clk) #1;
    check("bp_b_data", out_data, eb[31:0]);
    check("bp_b_valid", out_valid, 1);
    drive(0, 16'hA5A5, 0, 0);
    @(posedge clk) #1;
    check("bp_c_data", out_data, ec[31:0]);
    check("bp_c_valid", out_valid, 1);
    drive(7, 0, 32'h13572468, 0);
    @(posedge clk) #1;
    check("bp_d_data", out_data, ed[31:0]);
    check("bp_d_valid", out_valid, 1);
    in_valid = 0;
    @(posedge clk) #1;
    check("bp_end_valid", out_valid, 0);
    // asynchronous reset mid-cycle while holding a beat
    out_ready = 0;
    drive(1, 16'hBEEF, 0, 0);
    @(posedge clk) #1;
    check("ar_pre_valid", out_valid, 1);
    in_valid = 0;
    #2 rst_n = 0;
    #1;
    check("ar_valid", out_valid, 0);
    check("ar_data", out_data, 0);
    check("ar_ready", in_ready, 1);
    @(negedge clk) rst_n = 1;
    out_ready = 1;
    @(posedge clk) #1;
    check("ar_first_valid", out_valid, 0);
    drive(2, 16'h00FF, 0, 0);
    @(posedge clk) #1;
    check("ar_beat_valid", out_valid, 1);
    check("ar_beat_data", out_data, 32'h00FF0000);
    in_valid = 0;
    @(posedge clk) #1;
    // randomized traffic against a one-slot scoreboard
    mv = 0; mm = 0; md = 0;
    for (int c = 0; c < 400; c++) begin
      iv = $urandom_range(0, 3) != 0;
      orr = $urandom_range(0, 2) != 0;
      in_valid = iv; out_ready = orr;
      in_mode = 3'($urandom); in_imm = 16'($urandom);
      in_word = $urandom; in_offset = 2'($urandom);
      e = ref_m(in_mode, in_imm, in_word, in_offset);
      #1 check("rnd_ready", in_ready, !mv || orr);
      @(posedge clk);
      if (iv && (!mv || orr)) begin mv = 1; md = e[31:0]; mm = e[32]; end
      else if (orr) mv = 0;
      #1;
      check("rnd_valid", out_valid, mv);
      if (mv) begin
        check("rnd_data", out_data, md);
        check("rnd_mis", out_misalign, mm);
      end
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
